// File: rtl/router_pkg.sv
// Shared constants and width helper for the packet router synchronizer.
package router_pkg;

    localparam int DEFAULT_NUM_CH  = 3;
    localparam int DEFAULT_TIMEOUT = 30;

    // Counter width wide enough to hold the value TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: one-cycle soft_reset pulse after TIMEOUT consecutive
// cycles where the channel holds valid data that nobody reads.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = cnt_width(DEFAULT_TIMEOUT)
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_vld,
    input  logic i_rd,
    output logic o_soft_reset
);

    logic [CW-1:0] r_cnt;
    logic          r_soft_reset;

    // A read or an empty FIFO clears progress and wins over the terminal count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else begin
            r_soft_reset <= 1'b0;
            if (i_rd || !i_vld) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the packet destination, steers FIFO write enables
// and full status, and flushes any channel whose valid data sits unread too long.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEFAULT_NUM_CH,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [ADDR_W-1:0] r_addr_q;
    logic              r_addr_err;
    logic [NUM_CH-1:0] w_write_enb;
    logic              w_fifo_full;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr_q   <= '0;
            r_addr_err <= 1'b0;
        end else if (detect_add) begin
            r_addr_q   <= data_in;
            r_addr_err <= (32'(data_in) >= NUM_CH);
        end
    end

    // Decode uses the registered address, so a header arriving alongside a
    // write still steers that write to the previous destination.
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_addr_q == ADDR_W'(i)) begin
                w_write_enb[i] = write_enb_reg & ~r_addr_err & resetn;
                w_fifo_full    = full[i] & ~r_addr_err;
            end
        end
    end

    assign write_enb = w_write_enb;
    assign fifo_full = w_fifo_full;
    assign addr_err  = r_addr_err;
    assign vld_out   = ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CW      (CW)
        ) u_timer (
            .clock        (clock),
            .resetn       (resetn),
            .i_vld        (vld_out[g]),
            .i_rd         (read_enb[g]),
            .o_soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: default build plus a 5-channel, TIMEOUT=4 build.
module tb_router_sync_n;

    localparam int W = 16;

    logic clock;
    logic resetn;

    // Default instance: NUM_CH=3, ADDR_W=2, TIMEOUT=30
    logic [1:0] data_in;
    logic       detect_add;
    logic       write_enb_reg;
    logic [2:0] full, empty, read_enb;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic       fifo_full, addr_err;

    // Sweep instance: NUM_CH=5, ADDR_W=3, TIMEOUT=4
    logic [2:0] data_in2;
    logic       detect_add2;
    logic       write_enb_reg2;
    logic [4:0] full2, empty2, read_enb2;
    logic [4:0] write_enb2, vld_out2, soft_reset2;
    logic       fifo_full2, addr_err2;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    logic [W-1:0] acc;

    router_sync_n dut (
        .clock         (clock),
        .resetn        (resetn),
        .data_in       (data_in),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .full          (full),
        .empty         (empty),
        .read_enb      (read_enb),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out       (vld_out),
        .soft_reset    (soft_reset),
        .addr_err      (addr_err)
    );

    router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4)) dut2 (
        .clock         (clock),
        .resetn        (resetn),
        .data_in       (data_in2),
        .detect_add    (detect_add2),
        .write_enb_reg (write_enb_reg2),
        .full          (full2),
        .empty         (empty2),
        .read_enb      (read_enb2),
        .write_enb     (write_enb2),
        .fifo_full     (fifo_full2),
        .vld_out       (vld_out2),
        .soft_reset    (soft_reset2),
        .addr_err      (addr_err2)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic exp_push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    // Scoreboard pop/compare
    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h, expected queue empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    // Run n cycles and OR together every soft_reset value seen
    task automatic watch1(input int n, output logic [W-1:0] seen);
        seen = '0;
        repeat (n) begin
            tick(1);
            seen |= W'(soft_reset);
        end
    endtask

    task automatic watch2(input int n, output logic [W-1:0] seen);
        seen = '0;
        repeat (n) begin
            tick(1);
            seen |= W'(soft_reset2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        data_in = '0; detect_add = 1'b0; write_enb_reg = 1'b0;
        full = '0; empty = 3'b111; read_enb = '0;
        data_in2 = '0; detect_add2 = 1'b0; write_enb_reg2 = 1'b0;
        full2 = '0; empty2 = 5'b11111; read_enb2 = '0;
        tick(2);
        resetn = 1'b1;
        tick(2);

        // Reset mid-count at cnt=17
        empty = 3'b101;
        write_enb_reg = 1'b1;
        full = 3'b001;
        tick(17);
        resetn = 1'b0;
        #1;
        exp_push(W'(3'b000)); check("rst_soft_reset", W'(soft_reset));
        exp_push(W'(3'b000)); check("rst_write_enb", W'(write_enb));
        exp_push(W'(1'b0));   check("rst_addr_err", W'(addr_err));
        exp_push(W'(1'b1));   check("rst_fifo_full_is_full0", W'(fifo_full));
        exp_push(W'(3'b010)); check("rst_vld_out", W'(vld_out));
        tick(3);
        #2 resetn = 1'b1;
        write_enb_reg = 1'b0;
        watch1(29, acc);
        exp_push(W'(3'b000)); check("rst_no_early_pulse", acc);
        tick(1);
        exp_push(W'(3'b010)); check("rst_pulse_at_30", W'(soft_reset));
        empty = 3'b111;
        tick(2);

        // Decode
        data_in = 2'd2; detect_add = 1'b1;
        tick(1);
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
        #1;
        exp_push(W'(3'b100)); check("dec_write_enb", W'(write_enb));
        exp_push(W'(1'b1));   check("dec_fifo_full_set", W'(fifo_full));
        full = 3'b011;
        #1;
        exp_push(W'(1'b0));   check("dec_fifo_full_clr", W'(fifo_full));

        // Header with write in the same cycle: old address still steers
        data_in = 2'd0; detect_add = 1'b1;
        #1;
        exp_push(W'(3'b100)); check("same_cycle_pre_edge", W'(write_enb));
        tick(1);
        detect_add = 1'b0;
        #1;
        exp_push(W'(3'b001)); check("same_cycle_post_edge", W'(write_enb));

        // Illegal address
        data_in = 2'd3; detect_add = 1'b1; full = 3'b111;
        tick(1);
        detect_add = 1'b0;
        #1;
        exp_push(W'(1'b1));   check("ill_addr_err", W'(addr_err));
        exp_push(W'(3'b000)); check("ill_write_enb", W'(write_enb));
        exp_push(W'(1'b0));   check("ill_fifo_full", W'(fifo_full));
        data_in = 2'd0; detect_add = 1'b1;
        tick(1);
        detect_add = 1'b0;
        #1;
        exp_push(W'(1'b0));   check("legal_addr_err", W'(addr_err));
        exp_push(W'(3'b001)); check("legal_write_enb", W'(write_enb));
        write_enb_reg = 1'b0; full = '0;

        // Timeout on channel 1
        empty = 3'b101;
        watch1(29, acc);
        exp_push(W'(3'b000)); check("to_quiet_1", acc);
        tick(1);
        exp_push(W'(3'b010)); check("to_pulse_30", W'(soft_reset));
        tick(1);
        exp_push(W'(3'b000)); check("to_pulse_one_cycle", W'(soft_reset));
        watch1(28, acc);
        exp_push(W'(3'b000)); check("to_quiet_2", acc);
        tick(1);
        exp_push(W'(3'b010)); check("to_pulse_60", W'(soft_reset));
        empty = 3'b111;
        tick(2);

        // Rescue: read on the 30th cycle
        empty = 3'b101;
        watch1(29, acc);
        exp_push(W'(3'b000)); check("rescue_quiet", acc);
        read_enb = 3'b010;
        tick(1);
        exp_push(W'(3'b000)); check("rescue_suppressed", W'(soft_reset));
        read_enb = 3'b000;
        watch1(29, acc);
        exp_push(W'(3'b000)); check("rescue_quiet_after", acc);
        tick(1);
        exp_push(W'(3'b010)); check("rescue_next_pulse", W'(soft_reset));
        empty = 3'b111;
        tick(2);

        // Parameter sweep instance
        data_in2 = 3'd4; detect_add2 = 1'b1;
        tick(1);
        detect_add2 = 1'b0; write_enb_reg2 = 1'b1;
        #1;
        exp_push(W'(5'b10000)); check("sw_write_enb", W'(write_enb2));
        data_in2 = 3'd6; detect_add2 = 1'b1;
        tick(1);
        detect_add2 = 1'b0;
        #1;
        exp_push(W'(1'b1));     check("sw_addr_err", W'(addr_err2));
        exp_push(W'(5'b00000)); check("sw_write_enb_ill", W'(write_enb2));
        write_enb_reg2 = 1'b0;
        empty2 = 5'b10111;
        watch2(3, acc);
        exp_push(W'(5'b00000)); check("sw_quiet_1", acc);
        tick(1);
        exp_push(W'(5'b01000)); check("sw_pulse_4", W'(soft_reset2));
        watch2(3, acc);
        exp_push(W'(5'b00000)); check("sw_quiet_2", acc);
        tick(1);
        exp_push(W'(5'b01000)); check("sw_pulse_8", W'(soft_reset2));

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
